// File: rtl/sram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM byte-row access controller:
//   - state_t and the ST_* state encodings for the access sequencer
//   - phase_cnt_w(): width of the per-phase cycle counter, derived from the
//     setup/pulse/hold cycle counts
// ----------------------------------------------------------------------------
package sram_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_PULSE = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_RESP  = 3'd4;

   // The counter runs 0..len-1 inside a phase, so it must hold the longest
   // phase length minus one. Never narrower than one bit.
   function automatic int phase_cnt_w(input int setup_cyc, input int pulse_cyc,
                                      input int hold_cyc);
      int longest;
      longest = setup_cyc;
      if (pulse_cyc > longest) longest = pulse_cyc;
      if (hold_cyc > longest)  longest = hold_cyc;
      return (longest <= 2) ? 1 : $clog2(longest);
   endfunction

endpackage : sram_ctrl_pkg

// File: rtl/sram_wl_decode.sv
// ----------------------------------------------------------------------------
// sram_wl_decode
// Combinational row-address decoder.
//   addr   in   ADDR_W      row index (may exceed NUM_WORDS-1)
//   en     in   1           enables the one-hot output
//   onehot out  NUM_WORDS   one-hot word-line select, all zero when !en or
//                           when addr is out of range
//   oor    out  1           addr >= NUM_WORDS (independent of en)
// ----------------------------------------------------------------------------
module sram_wl_decode #(
   parameter int NUM_WORDS = 16,
   parameter int ADDR_W    = 5
) (
   input  logic [ADDR_W-1:0]    addr,
   input  logic                 en,
   output logic [NUM_WORDS-1:0] onehot,
   output logic                 oor
);

   logic [31:0] addr_ext;

   assign addr_ext = 32'(addr);
   assign oor      = (addr_ext >= 32'(NUM_WORDS));

   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      onehot = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         onehot[k] = en && (addr_ext == 32'(k));
      end
   end

endmodule : sram_wl_decode

// File: rtl/sram_byte_ctrl.sv
// ----------------------------------------------------------------------------
// sram_byte_ctrl
// Single-outstanding access initiator for a bank of NUM_WORDS byte rows.
// Each accepted request is sequenced as setup -> pulse -> hold on the row's
// word line, then answered over a response handshake.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (accepted only in IDLE)
//   req_we/req_addr/req_wdata  request: 1=write, row index, write byte
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_err          read byte (0 for writes/errors), out-of-range
//   wl                         one-hot word lines
//   sram_datain                shared write-data bus (0 for reads)
//   read_pulse/write_pulse     shared strobes
//   sram_dataout               row k at [k*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
module sram_byte_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_WORDS = 16,
   parameter int ADDR_W    = 5,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_we,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [DATA_W-1:0]           req_wdata,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        rsp_err,
   output logic [NUM_WORDS-1:0]        wl,
   output logic [DATA_W-1:0]           sram_datain,
   output logic                        read_pulse,
   output logic                        write_pulse,
   input  logic [NUM_WORDS*DATA_W-1:0] sram_dataout
);

   localparam int CNT_W = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                ready_en_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;

   logic                in_access;
   logic                phase_done;
   logic                req_fire;
   logic [ADDR_W-1:0]   dec_addr;
   logic                addr_oor;
   logic [NUM_WORDS-1:0] wl_sel;
   logic [DATA_W-1:0]   row_rd;

   assign in_access = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                      (state_q == ST_HOLD);

   // ready_en_q keeps req_ready low while reset is held even though the state
   // register already sits in IDLE.
   assign req_ready = ready_en_q && (state_q == ST_IDLE);
   assign req_fire  = req_valid && req_ready;

   // In IDLE the decoder inspects the incoming address for the range check;
   // during an access it drives the word line from the latched address.
   assign dec_addr = (state_q == ST_IDLE) ? req_addr : addr_q;

   sram_wl_decode #(
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_wl_decode (
      .addr   (dec_addr),
      .en     (in_access),
      .onehot (wl_sel),
      .oor    (addr_oor)
   );

   always_comb begin
      phase_done = 1'b0;
      case (state_q)
         ST_SETUP: phase_done = (cnt_q == CNT_W'(SETUP_CYC - 1));
         ST_PULSE: phase_done = (cnt_q == CNT_W'(PULSE_CYC - 1));
         ST_HOLD:  phase_done = (cnt_q == CNT_W'(HOLD_CYC - 1));
         default:  phase_done = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_fire)   state_d = addr_oor ? ST_RESP : ST_SETUP;
         ST_SETUP: if (phase_done) state_d = ST_PULSE;
         ST_PULSE: if (phase_done) state_d = ST_HOLD;
         ST_HOLD:  if (phase_done) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready)  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Word lines are one-hot, so the selected row is a plain AND-OR.
   always_comb begin
      row_rd = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (wl_sel[k]) row_rd = row_rd | sram_dataout[k*DATA_W +: DATA_W];
      end
   end

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order. The request
   // latches are reset too, so the response outputs read 0 straight out of
   // reset instead of carrying stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ready_en_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         state_q    <= state_d;
         cnt_q      <= (in_access && !phase_done) ? cnt_q + 1'b1 : '0;

         if (req_fire) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= addr_oor;
            rdata_q <= '0;
         end

         // Capture on the final pulse cycle: the row has had the whole pulse
         // to resolve and the word line is still up.
         if ((state_q == ST_PULSE) && phase_done && !we_q) begin
            rdata_q <= row_rd;
         end
      end
   end

   assign wl          = wl_sel;
   assign sram_datain = (in_access && we_q) ? wdata_q : '0;
   assign read_pulse  = (state_q == ST_PULSE) && !we_q;
   assign write_pulse = (state_q == ST_PULSE) &&  we_q;
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_rdata   = rsp_valid ? rdata_q : '0;
   assign rsp_err     = rsp_valid && err_q;

endmodule : sram_byte_ctrl

// File: doc/sram_byte_ctrl.md
Name: sram_byte_ctrl

Overview:
- Access initiator for a bank of NUM_WORDS SRAM byte rows, each row with its own word line, a shared data-in bus, shared read/write pulses and a per-row data-out bus.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences word line, data and pulse timing in three phases: setup, pulse, hold.
- Returns a response over a valid/ready handshake carrying read data and error status. The core-side memory interface connects here.

Parameters:
- DATA_W, 8, width of one row (byte).
- NUM_WORDS, 16, number of rows driven; legal addresses are 0..NUM_WORDS-1.
- ADDR_W, 5, request address width; it may exceed the legal range.
- SETUP_CYC, 1, cycles the word line and data are stable before the pulse (>=1).
- PULSE_CYC, 2, cycles the read/write pulse is high (>=1).
- HOLD_CYC, 1, cycles the word line and data are held after the pulse (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row index.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.
- wl  out  NUM_WORDS  one-hot word lines.
- sram_datain  out  DATA_W  shared write data bus.
- read_pulse  out  1  read strobe.
- write_pulse  out  1  write strobe.
- sram_dataout  in  NUM_WORDS*DATA_W  concatenated row outputs; row k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset: clk, rst_n; reset is asynchronous and active-low. While rst_n=0 all outputs are 0 and the FSM is in IDLE.
  - Assertion mid-operation immediately drops wl, read_pulse and write_pulse, aborts the access and discards any pending response.
- States: IDLE, SETUP, PULSE, HOLD, RESP. A phase counter sized for max(SETUP_CYC, PULSE_CYC, HOLD_CYC) counts cycles within each phase.
- IDLE:
  - req_ready=1; all strobes and wl are 0.
  - On req_valid&&req_ready, latch we, addr and wdata into internal registers.
  - Out-of-range address (addr>=NUM_WORDS): go directly to RESP with rsp_err=1 and rsp_rdata=0. No wl or pulse is ever asserted.
  - Otherwise go to SETUP.
- SETUP, SETUP_CYC cycles:
  - wl[addr]=1, all other wl bits 0.
  - sram_datain = latched wdata for writes, 0 for reads.
  - No pulse.
- PULSE, PULSE_CYC cycles:
  - wl and sram_datain held.
  - write_pulse=1 for writes, or read_pulse=1 for reads, never both.
  - For reads, capture sram_dataout row addr on the last PULSE cycle.
- HOLD, HOLD_CYC cycles: wl and sram_datain held, both pulses 0. Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_ready.
  - wl=0 and sram_datain=0.
  - On rsp_ready, go to IDLE.
- Handshake rules:
  - req_ready is 0 in every state except IDLE. A new request is accepted no earlier than the cycle after the response handshake.
  - rsp_valid is never dropped without rsp_ready.
- Fixed latency for a legal access, from the request handshake to the first rsp_valid cycle: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles (5 with defaults).
- Error latency: 1 cycle.
- Invariants:
  - At most one wl bit is high.
  - A pulse is high only while its wl is high.
  - Pulses have no overlap with wl edges.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package sram_ctrl_pkg holds the state enum (IDLE/SETUP/PULSE/HOLD/RESP) and a function to compute the phase-counter width from the timing parameters.
- One natural sub-module, sram_wl_decode: combinational address-to-one-hot decoder with enable and out-of-range flag. Everything else stays in sram_byte_ctrl.

Test Plan:
- Write then read, defaults: write addr 3 data 0xA5, then read addr 3.
  - Write: write_pulse high exactly 2 cycles with wl=16'h0008.
  - Read: rsp_valid 5 cycles after acceptance, rsp_rdata=0xA5, rsp_err=0.
- Out-of-range: read addr 20 → rsp_valid on the next cycle with rsp_err=1, rsp_rdata=0. wl, read_pulse and write_pulse stay 0 throughout.
- Response backpressure: hold rsp_ready=0 for 4 cycles after rsp_valid.
  - rsp_rdata and rsp_err stay stable and req_ready=0 throughout.
  - After rsp_ready, req_ready=1 the next cycle.
- Reset mid-pulse: assert rst_n=0 during the second write_pulse cycle.
  - Same cycle: wl=0, write_pulse=0 and rsp_valid=0.
  - After release: req_ready=1 and no response emitted.
- Timing parameters SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2:
  - read_pulse is high exactly 3 cycles; wl leads it by 2 cycles and trails it by 2.
  - Latency is 8 cycles.
- Back-to-back writes to addr 0 and addr 15 with req_valid held high: the second request is accepted only after the first response handshake, and wl=16'h8000 only during the second access.
